// File: rtl/v7_peak_detector.sv
// Peak detector after the trapezoidal shaper: finds pulses above threshold
// and emits one amplitude/time/width record per pulse over valid/ready.
module v7_peak_detector #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int THRESHOLD        = 100,
  parameter int DEAD_TIME        = 4,
  parameter int MAX_WIDTH        = 16,
  parameter int TS_WIDTH         = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
  input  logic                               peak_ready,
  output logic                               peak_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic        [TS_WIDTH-1:0]         peak_time,
  output logic        [7:0]                  peak_width,
  output logic                               peak_pileup,
  output logic        [15:0]                 drop_count,
  output logic                               overflow
);

  localparam int W = SIZE_FILTER_DATA;
  localparam logic signed [W-1:0] THR = W'(THRESHOLD);
  localparam logic [7:0] MW = 8'(MAX_WIDTH);
  localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [DW-1:0] DLAST =
    (DEAD_TIME > 0) ? DW'(DEAD_TIME - 1) : '0;

  typedef enum logic [2:0] {
    IDLE, ARMED, WAIT_LOW, REPORT, DEAD
  } state_e;

  state_e state_q, state_d;

  logic [TS_WIDTH-1:0] ts_cnt_q, ts_q;
  logic signed [W-1:0] s_q;
  logic signed [W-1:0] max_q, max_d;
  logic [TS_WIDTH-1:0] tmax_q, tmax_d;
  logic [7:0]          width_q, width_d, width_inc;
  logic                pile_q, pile_d;
  logic [DW-1:0]       dead_q, dead_d;
  logic                above;

  logic                load_d, drop_d, ld_q;
  logic signed [W-1:0] rec_amp_q;
  logic [TS_WIDTH-1:0] rec_t_q;
  logic [7:0]          rec_w_q;
  logic                rec_p_q;

  logic                vld_q;
  logic signed [W-1:0] amp_q;
  logic [TS_WIDTH-1:0] time_q;
  logic [7:0]          wid_q;
  logic                pil_q;
  logic [15:0]         drop_q;
  logic                ovf_q;

  assign above     = s_q > THR;
  assign width_inc = width_q + 8'd1;

  // Free-running timestamp and single input register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
      s_q      <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      ts_q     <= ts_cnt_q;
      s_q      <= input_data;
    end
  end

  // FSM state and pulse accumulator registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      max_q   <= '0;
      tmax_q  <= '0;
      width_q <= '0;
      pile_q  <= 1'b0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      tmax_q  <= tmax_d;
      width_q <= width_d;
      pile_q  <= pile_d;
      dead_q  <= dead_d;
    end
  end

  // Next state and accumulator update from the registered sample
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    tmax_d  = tmax_q;
    width_d = width_q;
    pile_d  = pile_q;
    dead_d  = dead_q;
    unique case (state_q)
      IDLE: begin
        if (above) begin
          max_d   = s_q;
          tmax_d  = ts_q;
          width_d = 8'd1;
          pile_d  = 1'b0;
          state_d = ARMED;
          if (MW == 8'd1) begin
            pile_d  = 1'b1;
            state_d = WAIT_LOW;
          end
        end
      end
      ARMED: begin
        if (above) begin
          width_d = width_inc;
          if (s_q > max_q) begin
            max_d  = s_q;
            tmax_d = ts_q;
          end
          if (width_inc == MW) begin
            pile_d  = 1'b1;
            state_d = WAIT_LOW;
          end
        end else begin
          state_d = REPORT;
        end
      end
      WAIT_LOW: begin
        if (!above) state_d = REPORT;
      end
      REPORT: begin
        dead_d  = '0;
        state_d = (DEAD_TIME == 0) ? IDLE : DEAD;
      end
      DEAD: begin
        if (dead_q == DLAST) state_d = IDLE;
        else dead_d = dead_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Report decision: load if slot is empty or being drained now
  always_comb begin
    load_d = 1'b0;
    drop_d = 1'b0;
    if (state_q == REPORT) begin
      if (!vld_q || peak_ready) load_d = 1'b1;
      else drop_d = 1'b1;
    end
  end

  // Staging register decouples the record from the next pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_q      <= 1'b0;
      rec_amp_q <= '0;
      rec_t_q   <= '0;
      rec_w_q   <= '0;
      rec_p_q   <= 1'b0;
    end else begin
      ld_q <= load_d;
      if (load_d) begin
        rec_amp_q <= max_q;
        rec_t_q   <= tmax_q;
        rec_w_q   <= width_q;
        rec_p_q   <= pile_q;
      end
    end
  end

  // Output slot: held until accepted, reload wins over drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      amp_q  <= '0;
      time_q <= '0;
      wid_q  <= '0;
      pil_q  <= 1'b0;
    end else if (ld_q) begin
      vld_q  <= 1'b1;
      amp_q  <= rec_amp_q;
      time_q <= rec_t_q;
      wid_q  <= rec_w_q;
      pil_q  <= rec_p_q;
    end else if (vld_q && peak_ready) begin
      vld_q <= 1'b0;
    end
  end

  // Saturating drop counter with sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else if (drop_d) begin
      ovf_q <= 1'b1;
      if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign peak_valid     = vld_q;
  assign peak_amplitude = amp_q;
  assign peak_time      = time_q;
  assign peak_width     = wid_q;
  assign peak_pileup    = pil_q;
  assign drop_count     = drop_q;
  assign overflow       = ovf_q;

endmodule
